btn_step_conditioner: RTL and testbench
=======================================

// Module: btn_step_conditioner
// PURPOSE
//  Conditions a raw board push-button into the clean single-cycle enable that drives
//  Pipeline.i_btn_enable_d_s_o (manual step/display advance). Sits directly upstream of Pipeline.
//  Chain: 2-FF synchronizer -> stable-level debounce FSM -> 1-cycle press pulse plus press counter.
// PARAMETERS
//  P_DEBOUNCE_CYCLES  20  consecutive stable synced cycles to accept an edge (>=2; board build ~1_000_000)
//  P_CNT_W            20  debounce counter width; must hold P_DEBOUNCE_CYCLES-1
//  P_REPEAT_DELAY     50  held cycles after accept before first auto-repeat pulse (macro only)
//  P_REPEAT_PERIOD    10  cycles between later auto-repeat pulses (macro only, >=1)
// PORTS
//  i_clk          in   1  system clock, rising edge
//  i_rst          in   1  synchronous reset, active-low (asserted when 0)
//  i_btn          in   1  raw asynchronous button level, active-high, bouncy
//  o_btn_pulse    out  1  one-cycle high per accepted press (feeds i_btn_enable_d_s_o)
//  o_btn_level    out  1  debounced button level
//  o_press_count  out  8  number of pulses emitted, wraps 255->0
// BEHAVIOUR
//  - Reset (i_rst==0 at clock edge): sync FFs=0, FSM=IDLE, counter=0, o_btn_pulse=0, o_btn_level=0,
//    o_press_count=0. Reset mid-press aborts everything; no pulse emitted after release of reset
//    until a full new debounce completes.
//  - All outputs registered. s = synchronizer output = i_btn delayed 2 cycles.
//  - FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
//    IDLE: s==1 -> PRESS_WAIT, counter=0.
//    PRESS_WAIT: s==1 -> counter++; when counter==P_DEBOUNCE_CYCLES-1 and s==1 -> PRESSED,
//      o_btn_pulse=1 for exactly that next cycle, o_btn_level=1, o_press_count++.
//      s==0 (bounce) -> IDLE, counter=0, no pulse.
//    PRESSED: s==0 -> RELEASE_WAIT, counter=0; s==1 -> stay.
//    RELEASE_WAIT: s==0 -> counter++; reaching P_DEBOUNCE_CYCLES-1 -> IDLE, o_btn_level=0.
//      s==1 (bounce) -> PRESSED, counter=0, no new pulse.
//  - Latency: i_btn first sampled high at edge k, stable -> o_btn_pulse high in cycle
//    k+2+P_DEBOUNCE_CYCLES. Release latency to o_btn_level=0 identical.
//  - o_btn_pulse never high two consecutive cycles; never high outside a PRESSED entry/repeat.
//  - Counter saturates at its compare value; never wraps within a state.
// CONFIGURATION
//  Macro BTN_AUTOREPEAT_EN.
//  Defined: in PRESSED with s==1, a repeat counter runs; pulse after P_REPEAT_DELAY held
//    cycles, then every P_REPEAT_PERIOD cycles; each pulse increments o_press_count.
//    Leaving PRESSED (incl. bounce to RELEASE_WAIT) clears repeat counter; return from
//    RELEASE_WAIT restarts the full P_REPEAT_DELAY.
//  Undefined: exactly one pulse per accepted press; repeat parameters unused, no repeat logic.
// STRUCTURE
//  - Shared Constants.vh: FSM state encodings (2-bit IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT)
//    and active-low reset level constant.
//  - One sub-module: btn_sync_2ff (2-flop synchronizer, reset to 0, same i_clk/i_rst).
//  - FSM, debounce counter, repeat counter, outputs in this module.
// TESTING  (P_DEBOUNCE_CYCLES=4, P_REPEAT_DELAY=8, P_REPEAT_PERIOD=3)
//  1 Reset: hold i_rst=0 3 cycles with i_btn=1 -> all outputs 0, no pulse during reset.
//  2 Clean press: i_btn 0->1 held 20 cycles -> single pulse 6 cycles after rise, level=1, count=1.
//  3 Bounce: i_btn high 2 cycles, low 1, high 2, low -> no pulse, count stays 0, level 0.
//  4 Release bounce: after accept, i_btn low 2 cycles then high -> no second pulse, level stays 1.
//  5 Reset mid-PRESS_WAIT: i_rst=0 at cycle 4 of debounce -> no pulse; re-press gives count=1.
//  6 BTN_AUTOREPEAT_EN: hold i_btn 30 cycles -> pulses at +6, +14, +17, +20,... count matches.
//    Undefined macro, same stimulus -> exactly one pulse.
//  Wrap: 256 clean presses -> o_press_count returns to 0.

Source files
------------

// File: rtl/btn_step_conditioner_pkg.sv
// Shared types and constants for the push-button step conditioner.
// Holds the debounce FSM state encoding and the active reset level.
package btn_step_conditioner_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

  localparam logic RstActive = 1'b0;

  // Bits needed to count 0 .. max_val-1, never less than one.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/btn_sync_2ff.sv
// Two-flop synchronizer for the raw asynchronous button level.
// Both flops clear on the synchronous active-low reset.
module btn_sync_2ff
  import btn_step_conditioner_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_rst == RstActive) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/btn_step_conditioner.sv
// Button conditioner: 2-FF sync -> stable-level debounce FSM -> one-cycle press pulse + count.
// Define BTN_AUTOREPEAT_EN to emit repeat pulses while the button stays held.
module btn_step_conditioner
  import btn_step_conditioner_pkg::*;
#(
  parameter int unsigned P_DEBOUNCE_CYCLES = 20,
  parameter int unsigned P_CNT_W           = 20,
  parameter int unsigned P_REPEAT_DELAY    = 50,
  parameter int unsigned P_REPEAT_PERIOD   = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic       o_btn_pulse,
  output logic       o_btn_level,
  output logic [7:0] o_press_count
);

  if ((P_DEBOUNCE_CYCLES < 2) || (P_REPEAT_DELAY < 1) || (P_REPEAT_PERIOD < 1) ||
      (((64'(P_DEBOUNCE_CYCLES) - 64'd1) >> P_CNT_W) != 64'd0)) begin : gen_cfg_err
    $error("btn_step_conditioner: illegal parameter combination");
  end

  localparam logic [P_CNT_W-1:0] CntMax = P_CNT_W'(P_DEBOUNCE_CYCLES - 1);

  logic               btn_s;
  btn_state_e         state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               level_q, level_d;
  logic [7:0]         count_q, count_d;
  logic               rep_fire;

  btn_sync_2ff u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_btn),
    .o_q   (btn_s)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepMax = (P_REPEAT_DELAY > P_REPEAT_PERIOD) ? P_REPEAT_DELAY :
                                                                        P_REPEAT_PERIOD;
  localparam int unsigned RepW   = cnt_bits(RepMax);
  localparam logic [RepW-1:0] RepDelayMax  = RepW'(P_REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodMax = RepW'(P_REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_q, rep_d;
  logic            rep_phase_q, rep_phase_d;

  // Anything other than a held PRESSED cycle clears the repeat timer back to the full delay.
  always_comb begin
    rep_d       = '0;
    rep_phase_d = 1'b0;
    rep_fire    = 1'b0;
    if ((state_q == StPressed) && btn_s) begin
      rep_d       = rep_q + 1'b1;
      rep_phase_d = rep_phase_q;
      if (rep_q == (rep_phase_q ? RepPeriodMax : RepDelayMax)) begin
        rep_fire    = 1'b1;
        rep_d       = '0;
        rep_phase_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst == RstActive) begin
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StPressed;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!btn_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else begin
          pulse_d = rep_fire;
        end
      end
      StReleaseWait: begin
        if (btn_s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    count_d = count_q + {7'd0, pulse_d};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst == RstActive) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign o_btn_pulse   = pulse_q;
  assign o_btn_level   = level_q;
  assign o_press_count = count_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Directed bench for btn_step_conditioner (debounce 4, repeat delay 8, repeat period 3).
// Expected pulse positions come from the latency rule: accept at edge k+6 after first high sample.
module tb_btn_step_conditioner;

  localparam int unsigned Deb    = 4;
  localparam int unsigned Delay  = 8;
  localparam int unsigned Period = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       pulse;
  logic       level;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  btn_step_conditioner #(
    .P_DEBOUNCE_CYCLES (Deb),
    .P_CNT_W           (20),
    .P_REPEAT_DELAY    (Delay),
    .P_REPEAT_PERIOD   (Period)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_btn         (btn),
    .o_btn_pulse   (pulse),
    .o_btn_level   (level),
    .o_press_count (cnt)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_count = 8'd0;

  int         pulse_log[$];
  bit         consec;
  logic [63:0] level_log;
  logic [7:0] cnt_log[64];

  // Pulses a held button produces after acceptance at 'entry', FSM seeing s=1 up to 'last_high'.
  function automatic int rep_pulses(input int entry, input int last_high);
    int n = 0;
    int t = entry + int'(Delay);
    while (t <= last_high) begin
      n++;
      t += int'(Period);
    end
    return AutoRep ? n : 0;
  endfunction

  function automatic int last_pulse(input int entry, input int last_high);
    int last = entry;
    int t = entry + int'(Delay);
    while (t <= last_high) begin
      last = t;
      t += int'(Period);
    end
    return AutoRep ? last : entry;
  endfunction

  // Rel index i = i-th edge after the drive starts; outputs sampled 1 time unit after it.
  task automatic drive_pattern(input logic [63:0] pat, input logic [63:0] rst_pat, input int len);
    bit prev = 1'b0;
    pulse_log.delete();
    consec    = 1'b0;
    level_log = '0;
    for (int i = 0; i < len; i++) begin
      btn   = pat[i];
      rst_n = ~rst_pat[i];
      @(posedge clk);
      #1;
      if (pulse === 1'b1) begin
        if (prev) consec = 1'b1;
        pulse_log.push_back(i);
      end
      prev         = (pulse === 1'b1);
      level_log[i] = level;
      cnt_log[i]   = cnt;
    end
    btn   = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pulse cyc%0d: got %b expected 0", i, pulse);
      end
      n_checks++;
      if (level !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_level cyc%0d: got %b expected 0", i, level);
      end
      n_checks++;
      if (cnt !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_count cyc%0d: got %0d expected 0", i, cnt);
      end
    end
    btn = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_count = 8'd0;
  endtask

  task automatic test_clean_press();
    int exp_n = 1 + rep_pulses(6, 21);
    drive_pattern(64'hF_FFFF, 64'd0, 30);
    exp_count += 8'(exp_n);
    n_checks++;
    if (pulse_log.size() != exp_n) begin
      n_fail++;
      $display("FAIL clean_pulse_count: got %0d expected %0d", pulse_log.size(), exp_n);
    end
    n_checks++;
    if (pulse_log.size() == 0 || pulse_log[0] != 6) begin
      n_fail++;
      $display("FAIL clean_first_pulse_rel: got %0d expected 6",
               (pulse_log.size() == 0) ? -1 : pulse_log[0]);
    end
    n_checks++;
    if (pulse_log.size() == 0 || pulse_log[$] != last_pulse(6, 21)) begin
      n_fail++;
      $display("FAIL clean_last_pulse_rel: got %0d expected %0d",
               (pulse_log.size() == 0) ? -1 : pulse_log[$], last_pulse(6, 21));
    end
    n_checks++;
    if (level_log[6:5] !== 2'b10) begin
      n_fail++;
      $display("FAIL clean_level_rise: got %b expected 10", level_log[6:5]);
    end
    n_checks++;
    if (level_log[26:25] !== 2'b01) begin
      n_fail++;
      $display("FAIL clean_level_fall: got %b expected 01", level_log[26:25]);
    end
    n_checks++;
    if (consec) begin
      n_fail++;
      $display("FAIL clean_consecutive_pulse: got 1 expected 0");
    end
    n_checks++;
    if (cnt !== exp_count) begin
      n_fail++;
      $display("FAIL clean_count: got %0d expected %0d", cnt, exp_count);
    end
  endtask

  task automatic test_bounce();
    drive_pattern(64'h1B, 64'd0, 14);
    n_checks++;
    if (pulse_log.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_pulses: got %0d expected 0", pulse_log.size());
    end
    n_checks++;
    if (level_log[13:0] !== 14'd0) begin
      n_fail++;
      $display("FAIL bounce_level: got %b expected all 0", level_log[13:0]);
    end
    n_checks++;
    if (cnt !== exp_count) begin
      n_fail++;
      $display("FAIL bounce_count: got %0d expected %0d", cnt, exp_count);
    end
  endtask

  task automatic test_release_bounce();
    int exp_n = 1 + rep_pulses(6, 11) + rep_pulses(14, 23);
    drive_pattern(64'h3FF | (64'h3FF << 12), 64'd0, 34);
    exp_count += 8'(exp_n);
    n_checks++;
    if (pulse_log.size() != exp_n) begin
      n_fail++;
      $display("FAIL relbounce_pulses: got %0d expected %0d", pulse_log.size(), exp_n);
    end
    n_checks++;
    if (level_log[27:6] !== {22{1'b1}}) begin
      n_fail++;
      $display("FAIL relbounce_level_held: got %b expected all 1", level_log[27:6]);
    end
    n_checks++;
    if (level_log[28] !== 1'b0) begin
      n_fail++;
      $display("FAIL relbounce_level_fall: got %b expected 0", level_log[28]);
    end
    n_checks++;
    if (cnt !== exp_count) begin
      n_fail++;
      $display("FAIL relbounce_count: got %0d expected %0d", cnt, exp_count);
    end
  endtask

  task automatic test_reset_mid_debounce();
    // Button held through a reset at rel 4; a fresh debounce starts at rel 5.
    drive_pattern(64'h7FFF, 64'h10, 30);
    exp_count = 8'd1;
    n_checks++;
    if (cnt_log[4] !== 8'd0 || level_log[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got count %0d level %b expected 0 0",
               cnt_log[4], level_log[4]);
    end
    n_checks++;
    if (pulse_log.size() != 1) begin
      n_fail++;
      $display("FAIL midrst_pulses: got %0d expected 1", pulse_log.size());
    end
    n_checks++;
    if (pulse_log.size() == 0 || pulse_log[0] != 11) begin
      n_fail++;
      $display("FAIL midrst_pulse_rel: got %0d expected 11",
               (pulse_log.size() == 0) ? -1 : pulse_log[0]);
    end
    n_checks++;
    if (cnt !== exp_count) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d expected %0d", cnt, exp_count);
    end
  endtask

  task automatic test_autorepeat();
    int exp_n = 1 + rep_pulses(6, 31);
    drive_pattern(64'h3FFF_FFFF, 64'd0, 42);
    exp_count += 8'(exp_n);
    n_checks++;
    if (pulse_log.size() != exp_n) begin
      n_fail++;
      $display("FAIL hold_pulses: got %0d expected %0d", pulse_log.size(), exp_n);
    end
    n_checks++;
    if (pulse_log.size() == 0 || pulse_log[$] != last_pulse(6, 31)) begin
      n_fail++;
      $display("FAIL hold_last_pulse_rel: got %0d expected %0d",
               (pulse_log.size() == 0) ? -1 : pulse_log[$], last_pulse(6, 31));
    end
    n_checks++;
    if (consec) begin
      n_fail++;
      $display("FAIL hold_consecutive_pulse: got 1 expected 0");
    end
    n_checks++;
    if (cnt !== exp_count) begin
      n_fail++;
      $display("FAIL hold_count: got %0d expected %0d", cnt, exp_count);
    end
  endtask

  task automatic test_wrap();
    int total = 0;
    drive_pattern(64'd0, 64'h1, 3);
    exp_count = 8'd0;
    for (int p = 0; p < 256; p++) begin
      drive_pattern(64'h3F, 64'd0, 14);
      total += pulse_log.size();
      exp_count += 8'd1;
      if (p == 254) begin
        n_checks++;
        if (cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_count_255: got %0d expected 255", cnt);
        end
      end
    end
    n_checks++;
    if (total != 256) begin
      n_fail++;
      $display("FAIL wrap_total_pulses: got %0d expected 256", total);
    end
    n_checks++;
    if (cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_count_0: got %0d expected 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    test_autorepeat();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
